// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit core: opcode map, fetch FSM encoding and
// field widths used by the fetch unit and the decode/execute datapath.
package cpu_pkg;

  localparam int OPCODE_W = 3;

  localparam logic [OPCODE_W-1:0] OP_LDI = 3'b000;
  localparam logic [OPCODE_W-1:0] OP_MOV = 3'b001;
  localparam logic [OPCODE_W-1:0] OP_ADD = 3'b010;
  localparam logic [OPCODE_W-1:0] OP_SUB = 3'b011;
  localparam logic [OPCODE_W-1:0] OP_AND = 3'b100;
  localparam logic [OPCODE_W-1:0] OP_OR  = 3'b101;
  localparam logic [OPCODE_W-1:0] OP_JMP = 3'b110;
  localparam logic [OPCODE_W-1:0] OP_BR  = 3'b111;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection for the fetch unit: sequential increment, jump, or taken
// branch. Jump has priority; the target comes from the operand field.
module pc_next_sel #(
  parameter int ADDR_W = 5,
  parameter int OPND_W = 5
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [OPND_W-1:0] operand,
  input  logic              jump,
  input  logic              branch,
  input  logic              cond_flag,
  output logic [ADDR_W-1:0] pc_next
);

  logic [ADDR_W-1:0] target;

  // Wide operands are truncated to the address space, narrow ones zero-extended.
  generate
    if (OPND_W >= ADDR_W) begin : g_trunc
      assign target = operand[ADDR_W-1:0];
    end else begin : g_zext
      assign target = {{(ADDR_W-OPND_W){1'b0}}, operand};
    end
  endgenerate

  always_comb begin
    pc_next = pc + ADDR_W'(1);
    if (jump) begin
      pc_next = target;
    end else if (branch && cond_flag) begin
      pc_next = target;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: reads program memory one word at a time, holds the word in
// the instruction register and hands opcode/operand to control/execute.
//
//   state   | meaning
//   S_REQ   | strobe mem_req for one cycle at mem_addr = pc
//   S_WAIT  | read outstanding, capture IR on mem_rvalid
//   S_ISSUE | instr_valid high, wait for exec_ready, then select next pc
//   S_HALT  | fetch stopped, only rst leaves
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int INSTR_W  = 8,
  parameter int RESET_PC = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [INSTR_W-1:0]    mem_rdata,
  input  logic                  mem_rvalid,
  output logic [OPCODE_W-1:0]   opcode,
  output logic [INSTR_W-4:0]    operand,
  output logic                  instr_valid,
  input  logic                  exec_ready,
  input  logic                  jump,
  input  logic                  branch,
  input  logic                  cond_flag,
  input  logic                  halt_req,
  output logic [ADDR_W-1:0]     pc,
  output logic                  halted
);

  localparam int OPND_W = INSTR_W - OPCODE_W;

  fetch_state_t        state;
  logic [INSTR_W-1:0]  ir;
  logic [ADDR_W-1:0]   pc_next;
  logic                handshake;

  assign opcode    = ir[INSTR_W-1 -: OPCODE_W];
  assign operand   = ir[OPND_W-1:0];
  assign mem_addr  = pc;
  assign handshake = instr_valid && exec_ready;

  pc_next_sel #(
    .ADDR_W (ADDR_W),
    .OPND_W (OPND_W)
  ) u_pc_next_sel (
    .pc        (pc),
    .operand   (operand),
    .jump      (jump),
    .branch    (branch),
    .cond_flag (cond_flag),
    .pc_next   (pc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_REQ;
      pc          <= ADDR_W'(RESET_PC);
      ir          <= '0;
      mem_req     <= 1'b0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        // Out of reset mem_req is low, so the first S_REQ cycle raises it;
        // from S_ISSUE it is raised on the way in and the strobe follows at once.
        S_REQ: begin
          if (!mem_req) begin
            mem_req <= 1'b1;
          end else begin
            mem_req <= 1'b0;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            ir          <= mem_rdata;
            instr_valid <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (handshake) begin
            pc          <= pc_next;
            instr_valid <= 1'b0;
            if (halt_req) begin
              halted <= 1'b1;
              state  <= S_HALT;
            end else begin
              mem_req <= 1'b1;
              state   <= S_REQ;
            end
          end
        end
        S_HALT: begin
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule
